// File: rtl/bw_io_ddr_vref_ctl_pkg.sv
// Shared definitions for the DDR Vref code path: code width and the
// controller state encoding, also used by the repeater and CSR decode.
package bw_io_ddr_vref_ctl_pkg;

    localparam int VREF_CODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SETTLE = 2'd2
    } vref_state_e;

    // Counter width for a modulo-m counter; never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bw_io_ddr_vref_divcnt.sv
// Modulo-MOD counter with synchronous clear, enable and terminal count.
// tc is asserted only on an enabled cycle at MOD-1, i.e. the cycle on
// which the counter wraps back to zero.
module bw_io_ddr_vref_divcnt
    import bw_io_ddr_vref_ctl_pkg::*;
#(
    parameter int MOD = 4,
    localparam int W  = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc = en && (cnt == LAST);

    // Count while enabled, wrap on terminal count, clear has priority.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bw_io_ddr_vref_ctl.sv
// DDR Vref code source. Accepts a target code from the CSR side and ramps
// the ladder code one LSB every STEP_DIV cycles, holds SETTLE_CYC cycles at
// the target, then pulses done.
//
// Handshake: a write transfers on a rising clock edge where wr_vld and
// wr_rdy are both high; wr_code is sampled on that edge. wr_rdy is high only
// in IDLE. An offer made while busy is dropped, not queued, and the CSR side
// must offer again once wr_rdy is high.
module bw_io_ddr_vref_ctl
    import bw_io_ddr_vref_ctl_pkg::*;
#(
    parameter int               WIDTH      = VREF_CODE_W,
    parameter int               STEP_DIV   = 4,
    parameter int               SETTLE_CYC = 16,
    parameter logic [WIDTH-1:0] RESET_CODE = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_code,
    output logic             wr_rdy,
    input  logic             freeze,
    output logic [WIDTH-1:0] vref_code,
    output logic             busy,
    output logic             done,
    output vref_state_e      state_dbg
);

    vref_state_e      state_q, state_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             done_q, done_d;

    logic div_tc, set_tc;
    logic [cnt_w(STEP_DIV)-1:0]   div_cnt;
    logic [cnt_w(SETTLE_CYC)-1:0] set_cnt;

    // Step divider: runs only while ramping and not frozen, held at zero otherwise.
    bw_io_ddr_vref_divcnt #(.MOD(STEP_DIV)) u_div (
        .clk (clk),
        .rst (rst),
        .clr (state_q != ST_RAMP),
        .en  ((state_q == ST_RAMP) && !freeze),
        .cnt (div_cnt),
        .tc  (div_tc)
    );

    // Settle timer: runs only while settling and not frozen.
    bw_io_ddr_vref_divcnt #(.MOD(SETTLE_CYC)) u_set (
        .clk (clk),
        .rst (rst),
        .clr (state_q != ST_SETTLE),
        .en  ((state_q == ST_SETTLE) && !freeze),
        .cnt (set_cnt),
        .tc  (set_tc)
    );

    // Next-state, next-code and done-pulse decode.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_vld) begin
                    tgt_d   = wr_code;
                    state_d = (wr_code == code_q) ? ST_SETTLE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (div_tc) begin
                    // Unsigned compare: the ramp never wraps through 0/max.
                    code_d = (tgt_q > code_q) ? code_q + 1'b1 : code_q - 1'b1;
                    if (code_d == tgt_q) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (set_tc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, code, target and done registers; reset snaps the code to mid-rail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= RESET_CODE;
            tgt_q   <= RESET_CODE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign wr_rdy    = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RAMP) || (state_q == ST_SETTLE);
    assign done      = done_q;
    assign vref_code = code_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bw_io_ddr_vref_ctl.sv
// Directed bench for bw_io_ddr_vref_ctl (STEP_DIV=4, SETTLE_CYC=16).
module tb_bw_io_ddr_vref_ctl;
    import bw_io_ddr_vref_ctl_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         wr_vld;
    logic [W-1:0] wr_code;
    logic         wr_rdy;
    logic         freeze;
    logic [W-1:0] vref_code;
    logic         busy;
    logic         done;
    vref_state_e  state_dbg;

    int n_tests;
    int n_fail;
    logic [W-1:0] exp_code;
    logic [W-1:0] exp_q[$];

    bw_io_ddr_vref_ctl #(
        .WIDTH      (W),
        .STEP_DIV   (4),
        .SETTLE_CYC (16),
        .RESET_CODE (8'h80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_vld    (wr_vld),
        .wr_code   (wr_code),
        .wr_rdy    (wr_rdy),
        .freeze    (freeze),
        .vref_code (vref_code),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_code = 8'h80;
        check_eq("rst_code", {24'd0, vref_code}, 32'h80);
        check_eq("rst_rdy",  {31'd0, wr_rdy}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
    endtask

    // One transfer from the current code to tgt, checked every cycle against
    // a timing model in non-frozen edges: step i lands at 4*i, done at 4*d+16.
    // frz_lo..frz_hi: edges with freeze high; noise_at: 3-cycle dropped offer;
    // rst_at: edge on which reset is applied (0 = none).
    task automatic run_xfer(input logic [W-1:0] tgt, input int frz_lo, input int frz_hi,
                            input int noise_at, input int rst_at, input string tag);
        logic [W-1:0] start;
        int d, done_at, eff, steps;
        bit frz, fin;
        start   = exp_code;
        d       = (tgt > start) ? int'(tgt - start) : int'(start - tgt);
        done_at = 4 * d + 16;
        eff     = 0;
        fin     = 0;
        check_eq({tag, "_rdy_pre"}, {31'd0, wr_rdy}, 32'd1);
        wr_vld  = 1'b1;
        wr_code = tgt;
        tick(1);
        wr_vld  = 1'b0;
        for (int k = 1; k <= 3000 && !fin; k++) begin
            frz     = (k >= frz_lo) && (k <= frz_hi);
            freeze  = frz;
            wr_vld  = (noise_at > 0) && (k >= noise_at) && (k < noise_at + 3);
            wr_code = wr_vld ? 8'h00 : tgt;
            rst     = (k == rst_at);
            tick(1);
            if (k == rst_at) begin
                rst    = 1'b0;
                freeze = 1'b0;
                exp_code = 8'h80;
                check_eq({tag, "_rst_code"}, {24'd0, vref_code}, 32'h80);
                check_eq({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                check_eq({tag, "_rst_rdy"},  {31'd0, wr_rdy}, 32'd1);
                for (int j = 0; j < 4; j++) begin
                    check_eq({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                    check_eq({tag, "_rst_hold"}, {24'd0, vref_code}, 32'h80);
                    tick(1);
                end
                return;
            end
            if (!frz) eff++;
            steps = (eff / 4 > d) ? d : eff / 4;
            exp_code = (tgt >= start) ? start + W'(steps) : start - W'(steps);
            exp_q.push_back(exp_code);
            check_eq({tag, "_code"}, {24'd0, vref_code}, {24'd0, exp_q.pop_front()});
            check_eq({tag, "_busy"}, {31'd0, busy}, {31'd0, eff < done_at});
            check_eq({tag, "_rdy"},  {31'd0, wr_rdy}, {31'd0, eff >= done_at});
            check_eq({tag, "_done"}, {31'd0, done}, {31'd0, (eff == done_at) && !frz});
            check_eq({tag, "_state"}, {30'd0, state_dbg},
                     (eff < 4 * d) ? 32'(ST_RAMP) : (eff < done_at) ? 32'(ST_SETTLE) : 32'(ST_IDLE));
            if (eff >= done_at + 1) fin = 1;
        end
        wr_vld = 1'b0;
        freeze = 1'b0;
        if (!fin) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_vld   = 1'b0;
        wr_code  = '0;
        freeze   = 1'b0;
        exp_code = 8'h80;
        tick(1);
        apply_reset();
        tick(2);

        // Same-code write: no ramp, settle only, done at accept+16.
        run_xfer(8'h80, 0, -1, 0, 0, "same");
        // Up ramp 0x80 -> 0x84, done at accept+32.
        run_xfer(8'h84, 0, -1, 0, 0, "up4");
        apply_reset();
        // Down ramp 0x80 -> 0x7E, must stop at 0x7E.
        run_xfer(8'h7E, 0, -1, 0, 0, "down2");
        // Offer of 0x00 while busy is dropped; ramp finishes to 0x82.
        run_xfer(8'h82, 0, -1, 5, 0, "ignore");
        // Freeze for 10 edges mid-ramp delays every later event by 10.
        run_xfer(8'h86, 6, 15, 0, 0, "freeze");
        // Reset mid-ramp snaps the code back, no done.
        run_xfer(8'h8A, 0, -1, 0, 10, "rstmid");
        // Back to normal operation after the aborted ramp.
        run_xfer(8'h81, 0, -1, 0, 0, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
